// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - game round sequencer: countdown, play, hit freeze, pause, game over, high score
// Owns lives, speed level and bar step divisor; all outputs come from registers.

module round_sequencer #(
   parameter int LIVES_INIT       = 3,
   parameter int START_DIV        = 6,
   parameter int MIN_DIV          = 2,
   parameter int ROUNDS_PER_LEVEL = 3,
   parameter int COUNT_TICKS      = 3,
   parameter int FLASH_TICKS      = 2
) (
   input  logic        gameclk,
   input  logic        clr,
   input  logic        tick_en,
   input  logic        start,
   input  logic        pause,
   input  logic        hit_evt,
   input  logic        pass_evt,
   input  logic [15:0] timealive,
   output logic [2:0]  state,
   output logic        run,
   output logic [2:0]  step_div,
   output logic [1:0]  lives,
   output logic [2:0]  level,
   output logic [1:0]  cd_value,
   output logic        flash,
   output logic        game_over,
   output logic [15:0] highscore
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_COUNTDOWN = 3'd1,
      S_PLAY      = 3'd2,
      S_HIT       = 3'd3,
      S_PAUSE     = 3'd4,
      S_OVER      = 3'd5
   } state_t;

   localparam logic [1:0] LIVES_LD   = 2'(LIVES_INIT);
   localparam logic [2:0] DIV_START  = 3'(START_DIV);
   localparam logic [2:0] DIV_MIN    = 3'(MIN_DIV);
   localparam logic [2:0] ROUND_LAST = 3'(ROUNDS_PER_LEVEL - 1);
   localparam logic [1:0] CD_LD      = 2'(COUNT_TICKS);
   localparam logic [2:0] FLASH_LD   = 3'(FLASH_TICKS);

   state_t     cur;
   state_t     nxt;
   logic [2:0] rounds;
   logic [2:0] flash_cnt;

   assign state = cur;

   // Hit outranks pass and pause in PLAY; anything not listed for a state holds.
   always_comb begin
      nxt = cur;
      case (cur)
         S_IDLE:      if (start) nxt = S_COUNTDOWN;
         S_COUNTDOWN: if (tick_en && cd_value == 2'd1) nxt = S_PLAY;
         S_PLAY: begin
            if (hit_evt)    nxt = (lives > 2'd1) ? S_HIT : S_OVER;
            else if (pause) nxt = S_PAUSE;
         end
         S_HIT:       if (tick_en && flash_cnt == 3'd1) nxt = S_PLAY;
         S_PAUSE:     if (pause) nxt = S_PLAY;
         S_OVER:      if (start) nxt = S_COUNTDOWN;
         default:     nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge gameclk or posedge clr) begin
      if (clr) begin
         cur       <= S_IDLE;
         run       <= 1'b0;
         flash     <= 1'b0;
         game_over <= 1'b0;
         step_div  <= DIV_START;
         lives     <= LIVES_LD;
         level     <= 3'd0;
         cd_value  <= 2'd0;
         highscore <= 16'd0;
         rounds    <= 3'd0;
         flash_cnt <= 3'd0;
      end else begin
         cur       <= nxt;
         run       <= (nxt == S_PLAY);
         flash     <= (nxt == S_HIT);
         game_over <= (nxt == S_OVER);
         case (cur)
            S_IDLE, S_OVER: begin
               if (start) begin
                  lives    <= LIVES_LD;
                  step_div <= DIV_START;
                  level    <= 3'd0;
                  rounds   <= 3'd0;
                  cd_value <= CD_LD;
               end
            end
            S_COUNTDOWN: begin
               if (tick_en) cd_value <= cd_value - 2'd1;
            end
            S_PLAY: begin
               if (hit_evt) begin
                  if (lives > 2'd1) begin
                     lives     <= lives - 2'd1;
                     flash_cnt <= FLASH_LD;
                  end else begin
                     lives <= 2'd0;
                     if (timealive > highscore) highscore <= timealive;
                  end
               end else if (pass_evt) begin
                  // Speed-up every ROUNDS_PER_LEVEL passes, saturating at MIN_DIV.
                  if (rounds == ROUND_LAST) begin
                     rounds <= 3'd0;
                     if (step_div > DIV_MIN) begin
                        step_div <= step_div - 3'd1;
                        level    <= level + 3'd1;
                     end
                  end else begin
                     rounds <= rounds + 3'd1;
                  end
               end
            end
            S_HIT: begin
               if (tick_en) flash_cnt <= flash_cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
